// File: rtl/fm_index_rom_server.sv
// Table server for the FM-index fetch stage: C, Occ (dual read) and read/D tables,
// filled over a valid/ready load port. Define ROM_ACCESS_CNT_EN for per-table access counters.
module fm_index_rom_server #(
  parameter int OCC_DEPTH = 256
`ifdef ROM_ACCESS_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [1:0]  load_sel,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        reload,
  output logic        tables_ready,
  output logic        load_err,
  output logic        access_err,
  input  logic        ce_rom_C,
  input  logic [1:0]  addr_rom_C,
  output logic [7:0]  data,
  input  logic        ce_rom_Occ,
  input  logic [7:0]  addr1_rom_Occ,
  input  logic [7:0]  addr2_rom_Occ,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  input  logic        ce_rom_read_and_D,
  input  logic [7:0]  addr_rom_read_and_D,
  output logic [7:0]  d_i,
  output logic [1:0]  read_i
`ifdef ROM_ACCESS_CNT_EN
  , output logic [CNT_W-1:0] cnt_C
  , output logic [CNT_W-1:0] cnt_Occ
  , output logic [CNT_W-1:0] cnt_RD
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t state, state_next;
  logic   accept;
  logic   is_ready;

  logic [7:0]  c_tab   [4];
  logic [31:0] occ_tab [OCC_DEPTH];
  logic [9:0]  rd_tab  [OCC_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_valid) state_next = LOAD;
      LOAD:    if (accept && load_last) state_next = READY;
      READY:   if (reload) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready   = (state == LOAD);
    tables_ready = (state == READY);
    is_ready     = (state == READY);
    accept       = load_valid && (state == LOAD);
  end

  // Table contents survive reset; only an accepted beat outside reset writes.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      case (load_sel)
        2'd0:    c_tab[load_addr[1:0]] <= load_data[7:0];
        2'd1:    occ_tab[load_addr]    <= load_data;
        2'd2:    rd_tab[load_addr]     <= load_data[9:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_err   <= 1'b0;
      access_err <= 1'b0;
    end else begin
      load_err   <= accept && (load_sel == 2'd3);
      access_err <= !is_ready && (ce_rom_C || ce_rom_Occ || ce_rom_read_and_D);
    end
  end

  // Each table's outputs hold unless its ce is high; reads outside READY return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data   <= '0;
      data_1 <= '0;
      data_2 <= '0;
      d_i    <= '0;
      read_i <= '0;
    end else begin
      if (ce_rom_C)
        data <= is_ready ? c_tab[addr_rom_C] : '0;
      if (ce_rom_Occ) begin
        data_1 <= is_ready ? occ_tab[addr1_rom_Occ] : '0;
        data_2 <= is_ready ? occ_tab[addr2_rom_Occ] : '0;
      end
      if (ce_rom_read_and_D) begin
        d_i    <= is_ready ? rd_tab[addr_rom_read_and_D][7:0] : '0;
        read_i <= is_ready ? rd_tab[addr_rom_read_and_D][9:8] : '0;
      end
    end
  end

`ifdef ROM_ACCESS_CNT_EN
  logic enter_load;
  assign enter_load = (state_next == LOAD) && (state != LOAD);

  always_ff @(posedge clk) begin
    if (!rst_n || enter_load) begin
      cnt_C   <= '0;
      cnt_Occ <= '0;
      cnt_RD  <= '0;
    end else if (is_ready) begin
      if (ce_rom_C && cnt_C != '1)            cnt_C   <= cnt_C + CNT_W'(1);
      if (ce_rom_Occ && cnt_Occ != '1)        cnt_Occ <= cnt_Occ + CNT_W'(1);
      if (ce_rom_read_and_D && cnt_RD != '1)  cnt_RD  <= cnt_RD + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fm_index_rom_server.sv
// Randomized bench for fm_index_rom_server against an array-based table model.
module tb_fm_index_rom_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, load_ready;
  logic [1:0]  load_sel;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_last, reload;
  logic        tables_ready, load_err, access_err;
  logic        ce_rom_C;
  logic [1:0]  addr_rom_C;
  logic [7:0]  data;
  logic        ce_rom_Occ;
  logic [7:0]  addr1_rom_Occ, addr2_rom_Occ;
  logic [31:0] data_1, data_2;
  logic        ce_rom_read_and_D;
  logic [7:0]  addr_rom_read_and_D;
  logic [7:0]  d_i;
  logic [1:0]  read_i;
`ifdef ROM_ACCESS_CNT_EN
  logic [15:0] cnt_C, cnt_Occ, cnt_RD;
`endif

  fm_index_rom_server dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .reload(reload), .tables_ready(tables_ready), .load_err(load_err),
    .access_err(access_err),
    .ce_rom_C(ce_rom_C), .addr_rom_C(addr_rom_C), .data(data),
    .ce_rom_Occ(ce_rom_Occ), .addr1_rom_Occ(addr1_rom_Occ),
    .addr2_rom_Occ(addr2_rom_Occ), .data_1(data_1), .data_2(data_2),
    .ce_rom_read_and_D(ce_rom_read_and_D),
    .addr_rom_read_and_D(addr_rom_read_and_D), .d_i(d_i), .read_i(read_i)
`ifdef ROM_ACCESS_CNT_EN
    , .cnt_C(cnt_C), .cnt_Occ(cnt_Occ), .cnt_RD(cnt_RD)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference contents and the expected value held on each output.
  logic [7:0]  m_c   [4];
  logic [31:0] m_occ [256];
  logic [9:0]  m_rd  [256];
  logic [7:0]  e_data;
  logic [31:0] e_d1, e_d2;
  logic [7:0]  e_di;
  logic [1:0]  e_ri;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [1:0] sel, input logic [7:0] addr,
                           input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    load_sel = sel; load_addr = addr; load_data = d; load_last = last;
    load_valid = 1'b1;
    while (load_ready !== 1'b1 && guard < 10) begin
      tick;
      guard++;
    end
    if (load_ready !== 1'b1) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL load_handshake: load_ready=%b required 1", load_ready);
    end
    tick;
    load_valid = 1'b0;
    load_last  = 1'b0;
    case (sel)
      2'd0:    m_c[addr[1:0]] = d[7:0];
      2'd1:    m_occ[addr]    = d;
      2'd2:    m_rd[addr]     = d[9:0];
      default: ;
    endcase
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    e_data = '0; e_d1 = '0; e_d2 = '0; e_di = '0; e_ri = '0;
    n_vec++;
    if ({load_ready, tables_ready, load_err, access_err} !== 4'b0000) begin
      n_miss++;
      $display("[TB] FAIL reset_flags: got %b required 0000",
               {load_ready, tables_ready, load_err, access_err});
    end
    n_vec++;
    if ({data, data_1, data_2, d_i, read_i} !== 82'd0) begin
      n_miss++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {data, data_1, data_2, d_i, read_i});
    end
    rst_n = 1'b1;
    tick;
    n_vec++;
    if ({load_ready, tables_ready} !== 2'b00) begin
      n_miss++;
      $display("[TB] FAIL idle_after_reset: got %b required 00", {load_ready, tables_ready});
    end
  endtask

  task automatic test_load_tables;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      d[7:0] = (i == 0) ? 8'd0 : (i == 1) ? 8'd10 : (i == 2) ? 8'd25 : 8'd40;
      load_beat(2'd0, 8'(i), d, 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      d = (i == 9) ? 32'h04030201 : (i == 20) ? 32'h08070605 : (i == 255) ? 32'h0 : $urandom;
      load_beat(2'd1, 8'(i), d, 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      if (i == 5) d[9:0] = {2'b10, 8'd7};
      load_beat(2'd2, 8'(i), d, (i == 255));
    end
    n_vec++;
    if ({tables_ready, load_ready} !== 2'b10) begin
      n_miss++;
      $display("[TB] FAIL ready_after_load: got %b required 10", {tables_ready, load_ready});
    end
  endtask

  task automatic test_spec_reads;
    ce_rom_C = 1'b1; addr_rom_C = 2'd2;
    ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd9; addr2_rom_Occ = 8'd20;
    ce_rom_read_and_D = 1'b1; addr_rom_read_and_D = 8'd5;
    tick;
    ce_rom_C = 1'b0; ce_rom_Occ = 1'b0; ce_rom_read_and_D = 1'b0;
    n_vec++;
    if (data !== 8'd25) begin
      n_miss++; $display("[TB] FAIL c_read: got %0d required 25", data);
    end
    n_vec++;
    if (data_1 !== 32'h04030201 || data_2 !== 32'h08070605) begin
      n_miss++; $display("[TB] FAIL occ_read: got %h/%h required 04030201/08070605", data_1, data_2);
    end
    n_vec++;
    if (read_i !== 2'b10 || d_i !== 8'd7) begin
      n_miss++; $display("[TB] FAIL rd_read: got %b/%0d required 10/7", read_i, d_i);
    end
    // Change addresses with ce low: outputs must hold.
    addr_rom_C = 2'd3; addr1_rom_Occ = 8'd0; addr2_rom_Occ = 8'd1; addr_rom_read_and_D = 8'd6;
    tick;
    n_vec++;
    if ({data, data_1, data_2, d_i, read_i} !== {8'd25, 32'h04030201, 32'h08070605, 8'd7, 2'b10}) begin
      n_miss++; $display("[TB] FAIL hold_no_ce: got %h", {data, data_1, data_2, d_i, read_i});
    end
    e_data = 8'd25; e_d1 = 32'h04030201; e_d2 = 32'h08070605; e_di = 8'd7; e_ri = 2'b10;
  endtask

  task automatic test_random_reads(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      ce_rom_C = 1'($urandom_range(0, 1));
      ce_rom_Occ = 1'($urandom_range(0, 1));
      ce_rom_read_and_D = 1'($urandom_range(0, 1));
      addr_rom_C = 2'($urandom);
      addr1_rom_Occ = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      addr2_rom_Occ = ($urandom_range(0, 3) == 0) ? addr1_rom_Occ : 8'($urandom);
      addr_rom_read_and_D = 8'($urandom);
      if (ce_rom_C) e_data = m_c[addr_rom_C];
      if (ce_rom_Occ) begin
        e_d1 = m_occ[addr1_rom_Occ];
        e_d2 = m_occ[addr2_rom_Occ];
      end
      if (ce_rom_read_and_D) begin
        e_di = m_rd[addr_rom_read_and_D][7:0];
        e_ri = m_rd[addr_rom_read_and_D][9:8];
      end
      tick;
      n_vec++;
      if ({data, data_1, data_2, d_i, read_i, access_err} !== {e_data, e_d1, e_d2, e_di, e_ri, 1'b0}) begin
        n_miss++;
        $display("[TB] FAIL random_read[%0d]: got %h/%h/%h/%h/%b err=%b required %h/%h/%h/%h/%b err=0",
                 n, data, data_1, data_2, d_i, read_i, access_err, e_data, e_d1, e_d2, e_di, e_ri);
      end
    end
    ce_rom_C = 1'b0; ce_rom_Occ = 1'b0; ce_rom_read_and_D = 1'b0;
  endtask

  task automatic test_access_and_load_err;
    reload = 1'b1;
    tick;
    reload = 1'b0;
    n_vec++;
    if ({load_ready, tables_ready} !== 2'b10) begin
      n_miss++; $display("[TB] FAIL reload_to_load: got %b required 10", {load_ready, tables_ready});
    end
    ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd9; addr2_rom_Occ = 8'd20;
    tick;
    ce_rom_Occ = 1'b0;
    e_d1 = '0; e_d2 = '0;
    n_vec++;
    if ({data_1, data_2} !== 64'd0 || access_err !== 1'b1 || load_ready !== 1'b1 || data !== e_data) begin
      n_miss++;
      $display("[TB] FAIL access_in_load: got d1=%h d2=%h err=%b rdy=%b c=%h required 0/0/1/1/%h",
               data_1, data_2, access_err, load_ready, data, e_data);
    end
    tick;
    n_vec++;
    if (access_err !== 1'b0 || load_ready !== 1'b1) begin
      n_miss++; $display("[TB] FAIL access_err_pulse: got err=%b rdy=%b required 0/1", access_err, load_ready);
    end
    load_beat(2'd3, 8'd5, $urandom, 1'b0);
    n_vec++;
    if (load_err !== 1'b1) begin
      n_miss++; $display("[TB] FAIL load_err_set: got %b required 1", load_err);
    end
    tick;
    n_vec++;
    if (load_err !== 1'b0) begin
      n_miss++; $display("[TB] FAIL load_err_pulse: got %b required 0", load_err);
    end
    load_beat(2'd0, 8'd0, {24'hABCDEF, m_c[0]}, 1'b1);
    n_vec++;
    if (tables_ready !== 1'b1) begin
      n_miss++; $display("[TB] FAIL ready_after_reload: got %b required 1", tables_ready);
    end
    ce_rom_C = 1'b1; addr_rom_C = 2'd1;
    ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd5; addr2_rom_Occ = 8'd5;
    ce_rom_read_and_D = 1'b1; addr_rom_read_and_D = 8'd5;
    e_data = m_c[1]; e_d1 = m_occ[5]; e_d2 = m_occ[5]; e_di = m_rd[5][7:0]; e_ri = m_rd[5][9:8];
    tick;
    ce_rom_C = 1'b0; ce_rom_Occ = 1'b0; ce_rom_read_and_D = 1'b0;
    n_vec++;
    if ({data, data_1, data_2, d_i, read_i} !== {e_data, e_d1, e_d2, e_di, e_ri}) begin
      n_miss++; $display("[TB] FAIL illegal_sel_no_write: got %h required %h",
                         {data, data_1, data_2, d_i, read_i}, {e_data, e_d1, e_d2, e_di, e_ri});
    end
  endtask

  task automatic test_reset_midload;
    logic [31:0] v;
    v = $urandom;
    reload = 1'b1;
    tick;
    reload = 1'b0;
    load_beat(2'd1, 8'd30, v, 1'b0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    e_data = '0; e_d1 = '0; e_d2 = '0; e_di = '0; e_ri = '0;
    n_vec++;
    if ({tables_ready, load_ready, data_1} !== 34'd0) begin
      n_miss++; $display("[TB] FAIL reset_midload: got rdy=%b lr=%b d1=%h required 0/0/0",
                         tables_ready, load_ready, data_1);
    end
    ce_rom_C = 1'b1; addr_rom_C = 2'd2;
    tick;
    ce_rom_C = 1'b0;
    n_vec++;
    if (data !== 8'd0 || access_err !== 1'b1 || load_ready !== 1'b0 || tables_ready !== 1'b0) begin
      n_miss++; $display("[TB] FAIL access_in_idle: got c=%h err=%b lr=%b tr=%b required 0/1/0/0",
                         data, access_err, load_ready, tables_ready);
    end
    load_beat(2'd2, 8'd7, $urandom, 1'b1);
    ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd30; addr2_rom_Occ = 8'hFF;
    e_d1 = m_occ[30]; e_d2 = m_occ[255];
    tick;
    ce_rom_Occ = 1'b0;
    n_vec++;
    if (tables_ready !== 1'b1 || data_1 !== v || data_2 !== 32'h0) begin
      n_miss++; $display("[TB] FAIL partial_kept: got tr=%b d1=%h d2=%h required 1/%h/0",
                         tables_ready, data_1, data_2, v);
    end
  endtask

`ifdef ROM_ACCESS_CNT_EN
  task automatic test_counters;
    reload = 1'b1;
    tick;
    reload = 1'b0;
    load_beat(2'd0, 8'd3, {24'h0, m_c[3]}, 1'b1);
    n_vec++;
    if ({cnt_C, cnt_Occ, cnt_RD} !== 48'd0) begin
      n_miss++; $display("[TB] FAIL cnt_cleared: got %0d/%0d/%0d required 0", cnt_C, cnt_Occ, cnt_RD);
    end
    ce_rom_C = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_rom_C = 2'(i);
      e_data = m_c[i];
      tick;
    end
    ce_rom_C = 1'b0;
    n_vec++;
    if (cnt_C !== 16'd3 || cnt_Occ !== 16'd0 || cnt_RD !== 16'd0) begin
      n_miss++; $display("[TB] FAIL cnt_count: got %0d/%0d/%0d required 3/0/0", cnt_C, cnt_Occ, cnt_RD);
    end
    reload = 1'b1;
    tick;
    reload = 1'b0;
    n_vec++;
    if (cnt_C !== 16'd0) begin
      n_miss++; $display("[TB] FAIL cnt_clear_on_load: got %0d required 0", cnt_C);
    end
    load_beat(2'd0, 8'd3, {24'h0, m_c[3]}, 1'b1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_sel = '0; load_addr = '0; load_data = '0;
    load_last = 1'b0; reload = 1'b0;
    ce_rom_C = 1'b0; addr_rom_C = '0; ce_rom_Occ = 1'b0; addr1_rom_Occ = '0;
    addr2_rom_Occ = '0; ce_rom_read_and_D = 1'b0; addr_rom_read_and_D = '0;
    test_reset;
    test_load_tables;
    test_spec_reads;
    test_random_reads(300);
    test_access_and_load_err;
    test_random_reads(100);
    test_reset_midload;
    test_random_reads(100);
`ifdef ROM_ACCESS_CNT_EN
    test_counters;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
